// File: rtl/parity_frame_chk.sv
// parity_frame_chk: accumulates XOR parity over 3-bit beats of a frame,
// checks it against the parity bit carried on the LAST beat, and reports
// parity error, length error and beat count with a one-cycle DONE pulse.
// Frames that reach MAXBEATS before LAST are reported as length errors
// and the rest of the frame is absorbed in DROP.
module parity_frame_chk #(
  parameter int MAXBEATS = 16,
  parameter bit EVENPAR  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in1_i,
  input  logic       in2_i,
  input  logic       in3_i,
  input  logic       vld_i,
  input  logic       last_i,
  input  logic       pin_i,
  output logic       rdy_o,
  output logic       done_o,
  output logic       perr_o,
  output logic       lerr_o,
  output logic [7:0] bcnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [7:0] MAX_CNT = 8'(MAXBEATS);

  logic [1:0] state_q, state_d;
  logic       acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       perr_q, perr_d;
  logic       lerr_q, lerr_d;
  logic [7:0] bcnt_q, bcnt_d;

  logic       beat_acc;
  logic       base_acc;
  logic [7:0] base_cnt;
  logic       sum_acc;
  logic [7:0] sum_cnt;
  logic       final_par;

  // RDY is a pure decode of the state register; only the report cycle stalls.
  assign rdy_o    = (state_q != ST_RPT);
  assign beat_acc = vld_i & rdy_o;

  // A frame always starts from a clean accumulator, so IDLE ignores acc_q/cnt_q.
  assign base_acc  = (state_q == ST_ACC) ? acc_q : 1'b0;
  assign base_cnt  = (state_q == ST_ACC) ? cnt_q : 8'd0;
  assign sum_acc   = base_acc ^ in1_i ^ in2_i ^ in3_i;
  assign sum_cnt   = base_cnt + 8'd1;
  assign final_par = sum_acc ^ pin_i;

  // Next-state and result computation; results only change on a report.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    lerr_d  = lerr_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (beat_acc) begin
          if (last_i) begin
            // Normal completion, including a frame ending exactly at MAXBEATS.
            state_d = ST_RPT;
            done_d  = 1'b1;
            perr_d  = EVENPAR ? final_par : ~final_par;
            lerr_d  = 1'b0;
            bcnt_d  = sum_cnt;
            acc_d   = 1'b0;
            cnt_d   = 8'd0;
          end else if (sum_cnt == MAX_CNT) begin
            // Frame too long: report now, swallow the remainder in DROP.
            state_d = ST_DROP;
            done_d  = 1'b1;
            perr_d  = 1'b0;
            lerr_d  = 1'b1;
            bcnt_d  = MAX_CNT;
            acc_d   = 1'b0;
            cnt_d   = MAX_CNT;
          end else begin
            state_d = ST_ACC;
            acc_d   = sum_acc;
            cnt_d   = sum_cnt;
          end
        end
      end
      ST_RPT: begin
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (beat_acc && last_i) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      lerr_q  <= 1'b0;
      bcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      lerr_q  <= lerr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign done_o = done_q;
  assign perr_o = perr_q;
  assign lerr_o = lerr_q;
  assign bcnt_o = bcnt_q;

endmodule

// File: tb/tb_parity_frame_chk.sv
// Bench for parity_frame_chk: two instances (MAXBEATS=4/even parity and
// MAXBEATS=16/odd parity) driven by a frame-level driver. Each frame's
// expected report is pushed into a per-instance queue when the frame is
// issued; a negedge monitor pops and compares whenever DONE is seen.
module tb_parity_frame_chk;

  typedef struct {
    logic       perr;
    logic       lerr;
    logic [7:0] bcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in1, in2, in3, vld, last, pin;
  logic [1:0] rdy, done, perr, lerr;
  logic [7:0] bcnt0, bcnt1;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  bit   rdy_next_chk[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_frame_chk #(.MAXBEATS(4), .EVENPAR(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .in1_i(in1[0]), .in2_i(in2[0]), .in3_i(in3[0]),
    .vld_i(vld[0]), .last_i(last[0]), .pin_i(pin[0]),
    .rdy_o(rdy[0]), .done_o(done[0]), .perr_o(perr[0]),
    .lerr_o(lerr[0]), .bcnt_o(bcnt0)
  );

  parity_frame_chk #(.MAXBEATS(16), .EVENPAR(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .in1_i(in1[1]), .in2_i(in2[1]), .in3_i(in3[1]),
    .vld_i(vld[1]), .last_i(last[1]), .pin_i(pin[1]),
    .rdy_o(rdy[1]), .done_o(done[1]), .perr_o(perr[1]),
    .lerr_o(lerr[1]), .bcnt_o(bcnt1)
  );

  function automatic int maxb(input int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic bit evenpar(input int d);
    return (d == 0);
  endfunction

  function automatic logic [7:0] bcnt_of(input int d);
    return (d == 0) ? bcnt0 : bcnt1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: the report depends only on the frame's length and the
  // number of ones in data plus parity bit.
  function automatic exp_t model(input int d, input logic [2:0] bq[$], input logic p);
    exp_t e;
    int   ones = 0;
    int   n = bq.size();
    for (int i = 0; i < n; i++) ones += $countones(bq[i]);
    ones += int'(p);
    if (n > maxb(d)) begin
      e.perr = 1'b0;
      e.lerr = 1'b1;
      e.bcnt = 8'(maxb(d));
    end else begin
      e.perr = evenpar(d) ? (ones % 2 != 0) : (ones % 2 == 0);
      e.lerr = 1'b0;
      e.bcnt = 8'(n);
    end
    return e;
  endfunction

  // Drive one frame beat by beat, retrying a beat until RDY accepts it.
  task automatic send_frame(input int d, input logic [2:0] bq[$], input logic p,
                            input bit with_last);
    exp_t e;
    int   n = bq.size();
    if (with_last) begin
      e = model(d, bq, p);
      if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      $display("frame dut%0d beats=%0d pin=%0d -> perr=%0d lerr=%0d bcnt=%0d",
               d, n, p, e.perr, e.lerr, e.bcnt);
    end
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      int tries = 0;
      do begin
        @(negedge clk);
        vld[d]  = 1'b1;
        in1[d]  = bq[i][2];
        in2[d]  = bq[i][1];
        in3[d]  = bq[i][0];
        last[d] = with_last && (i == n - 1);
        pin[d]  = (with_last && (i == n - 1)) ? p : 1'bx;
        ok      = rdy[d];
        tries++;
      end while (!ok && tries < 20);
      if (!ok) chk("rdy_wait", 32'(ok), 32'd1);
    end
  endtask

  task automatic idle(input int d, input int k);
    repeat (k) begin
      @(negedge clk);
      vld[d] = 1'b0; in1[d] = 1'bx; in2[d] = 1'bx; in3[d] = 1'bx;
      last[d] = 1'bx; pin[d] = 1'bx;
    end
  endtask

  task automatic drain(input int d);
    int t = 0;
    while (qsize(d) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(qsize(d)), 32'd0);
  endtask

  task automatic check_idle_outputs(input int d, input string nm);
    chk({nm, "_rdy"},  32'(rdy[d]),  32'd1);
    chk({nm, "_done"}, 32'(done[d]), 32'd0);
    chk({nm, "_perr"}, 32'(perr[d]), 32'd0);
    chk({nm, "_lerr"}, 32'(lerr[d]), 32'd0);
    chk({nm, "_bcnt"}, 32'(bcnt_of(d)), 32'd0);
  endtask

  task automatic check_done(input int d);
    exp_t e;
    if (qsize(d) == 0) begin
      chk("unexpected_done", 32'(done[d]), 32'd0);
      return;
    end
    if (d == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
    chk("perr", 32'(perr[d]), 32'(e.perr));
    chk("lerr", 32'(lerr[d]), 32'(e.lerr));
    chk("bcnt", 32'(bcnt_of(d)), 32'(e.bcnt));
    // Normal reports stall for one cycle; length-error reports do not.
    chk("rdy_in_done", 32'(rdy[d]), e.lerr ? 32'd1 : 32'd0);
    if (!e.lerr) rdy_next_chk[d] = 1'b1;
  endtask

  // Monitor: compare whenever an instance presents DONE.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rdy_next_chk[d]) begin
          chk("rdy_after_rpt", 32'(rdy[d]), 32'd1);
          rdy_next_chk[d] = 1'b0;
        end
        if (done[d]) check_done(d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] q[$];
    rst = 1'b1;
    vld = 2'b00; in1 = 'x; in2 = 'x; in3 = 'x; last = 'x; pin = 'x;
    #3;
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two-beat frames with good and bad parity, single beat, long frame.
    q = '{3'b100, 3'b110};
    send_frame(0, q, 1'b1, 1'b1); idle(0, 2);
    send_frame(0, q, 1'b0, 1'b1); idle(0, 2);
    send_frame(1, q, 1'b1, 1'b1); idle(1, 2);
    q = '{3'b111};
    send_frame(0, q, 1'b1, 1'b1); idle(0, 3);
    q = '{3'b101, 3'b010, 3'b111, 3'b001, 3'b110, 3'b011};
    send_frame(0, q, 1'b0, 1'b1); idle(0, 2);
    q = '{3'b011, 3'b001};
    send_frame(0, q, 1'b1, 1'b1); idle(0, 2);
    // Exactly MAXBEATS beats ending with LAST is a normal completion.
    q = '{3'b001, 3'b000, 3'b011, 3'b111};
    send_frame(0, q, 1'b0, 1'b1); idle(0, 2);
    // VLD held high across two frames.
    q = '{3'b110, 3'b100, 3'b001};
    send_frame(0, q, 1'b1, 1'b1);
    q = '{3'b010, 3'b011};
    send_frame(0, q, 1'b0, 1'b1); idle(0, 2);
    drain(0);
    drain(1);

    // Randomized frames, with random gaps (zero gap means back-to-back).
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 30; f++) begin
        int n = (d == 0) ? $urandom_range(1, 7) : $urandom_range(1, 20);
        int gap = $urandom_range(0, 2);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(3'($urandom_range(0, 7)));
        send_frame(d, q, 1'($urandom_range(0, 1)), 1'b1);
        if (gap != 0 || f == 29) idle(d, gap + ((f == 29) ? 2 : 0));
      end
      drain(d);
    end

    // Reset in the middle of a cycle after two beats of a frame.
    q = '{3'b111, 3'b101};
    send_frame(0, q, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    vld[0] = 1'b0;
    #1;
    check_idle_outputs(0, "midrst");
    @(negedge clk);
    rst = 1'b0;
    q = '{3'b001, 3'b010, 3'b100};
    send_frame(0, q, 1'b1, 1'b1); idle(0, 3);
    drain(0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
